layer0_input_packer: RTL

Upstream feeder for the layer-0 LUT neurons. It accepts one signed fixed-point input feature per beat over a valid/ready stream, quantizes each feature to QBITS unsigned bits, and assembles N_FEAT features into one flat input vector. It presents that vector to layer 0 with a valid/ready handshake, so the combinational neuron LUTs always see a stable, registered, complete frame.

---
 rtl/layer0_input_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/layer0_input_packer.sv
// -----------------------------------------------------------------------------
// layer0_input_packer
//
// Upstream feeder for the layer-0 LUT neurons. Signed fixed-point features
// arrive one per beat on a valid/ready stream. Each one is offset, shifted and
// clipped to QBITS unsigned bits, then written into a collect bank. When
// N_FEAT features have been gathered, the whole frame is copied into a
// registered output vector and offered downstream with a valid/ready
// handshake. The neuron LUTs therefore only ever see a stable, complete frame.
//
// Optional build macro: LAYER0_PACK_PINGPONG_EN
//   Undefined (default): single bank. Input is stalled while a packed vector
//                        waits for the downstream handshake.
//   Defined            : the collect bank and the output register form a
//                        ping-pong pair. The next frame is collected while the
//                        current vector waits. Input stalls only when the
//                        final slot would need to overwrite a vector that has
//                        not been taken yet.
// -----------------------------------------------------------------------------
module layer0_input_packer #(
    parameter int N_FEAT = 16,
    parameter int IN_W   = 16,
    parameter int QBITS  = 2,
    parameter int SHIFT  = 8,
    parameter int OFFSET = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_W-1:0]           s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N_FEAT*QBITS-1:0]   m_data,
    output logic                      err,
    output logic [15:0]               frame_cnt
);

    localparam int IDXW = $clog2(N_FEAT);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_FEAT - 1);

    // Offset and clip ceiling, widened to the two-guard-bit working width
    localparam logic signed [IN_W+1:0] OFF_EXT = (IN_W + 2)'(OFFSET);
    localparam logic signed [IN_W+1:0] QMAX    = (IN_W + 2)'((1 << QBITS) - 1);

    // FULL means a packed vector is waiting for the downstream handshake
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [IDXW-1:0]                  idx_q, idx_d;
    logic [N_FEAT-1:0][QBITS-1:0]     bank_q, bank_d;
    logic [N_FEAT*QBITS-1:0]          mData_q, mData_d;
    logic                             mValid_q, mValid_d;
    logic                             err_q, err_d;
    logic [15:0]                      frameCnt_q, frameCnt_d;

    logic signed [IN_W+1:0]           featExt;
    logic signed [IN_W+1:0]           sumT;
    logic signed [IN_W+1:0]           shiftU;
    logic [QBITS-1:0]                 qVal;
    logic                             accept;
    logic                             handshake;
    logic                             sReady;

    // Quantize the current input beat: add offset, arithmetic shift, clip
    always_comb begin
        featExt = {{2{s_data[IN_W-1]}}, s_data};
        sumT    = featExt + OFF_EXT;
        shiftU  = sumT >>> SHIFT;
        if (shiftU[IN_W+1]) begin
            qVal = '0;
        end else if (shiftU > QMAX) begin
            qVal = '1;
        end else begin
            qVal = shiftU[QBITS-1:0];
        end
    end

`ifdef LAYER0_PACK_PINGPONG_EN
    // Keep accepting while a vector waits; only the final slot must stall
    // until the pending vector has been taken (or is taken this cycle)
    assign sReady = !rst && !((idx_q == LAST_IDX) && mValid_q && !m_ready);
`else
    // Single bank: accept only while no vector is pending
    assign sReady = !rst && (state_q == COLLECT);
`endif

    assign accept    = s_valid && sReady;
    assign handshake = mValid_q && m_ready;

    // Next-state logic: frame assembly, output load and handshake release
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bank_d     = bank_q;
        mData_d    = mData_q;
        mValid_d   = mValid_q;
        frameCnt_d = frameCnt_q;
        err_d      = 1'b0;

        if (handshake) begin
            mValid_d = 1'b0;
            state_d  = COLLECT;
        end

        if (accept) begin
            bank_d[idx_q] = qVal;
            if (idx_q == LAST_IDX) begin
                // A completion in the same cycle as a handshake simply
                // reloads the output, so m_valid stays high
                mData_d    = bank_d;
                mValid_d   = 1'b1;
                state_d    = FULL;
                idx_d      = '0;
                frameCnt_d = frameCnt_q + 16'd1;
                err_d      = !s_last;
            end else if (s_last) begin
                // Early last: the partial frame is dropped and flagged
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            bank_q     <= '0;
            mData_q    <= '0;
            mValid_q   <= 1'b0;
            err_q      <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bank_q     <= bank_d;
            mData_q    <= mData_d;
            mValid_q   <= mValid_d;
            err_q      <= err_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    assign s_ready   = sReady;
    assign m_valid   = mValid_q;
    assign m_data    = mData_q;
    assign err       = err_q;
    assign frame_cnt = frameCnt_q;

endmodule
